// File: rtl/fib_exec_sequencer.sv
// Control FSM for the Fibonacci datapath: clears/steps it and streams each term MSB-first
// over a valid/ready byte link. Define FIB_SEQ_PACE_EN to insert pace_cycles between terms.
module fib_exec_sequencer #(
  parameter int unsigned bits        = 8,
  parameter int unsigned pace_cycles = 50_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  input  logic [7:0]      cmd_data,
  output logic            cmd_ready,
  input  logic            abort,
  output logic            dp_clear,
  output logic            dp_step,
  input  logic [bits-1:0] dp_value,
  input  logic            dp_ovf,
  output logic            tx_valid,
  output logic [7:0]      tx_data,
  input  logic            tx_ready,
  output logic [bits-1:0] Ro,
  output logic [7:0]      term_idx,
  output logic            busy,
  output logic            done,
  output logic            ovf_err
);

  localparam int unsigned NBYTES = (bits + 7) / 8;
  localparam int unsigned SW     = 8 * NBYTES;
  localparam int unsigned BCW    = $clog2(NBYTES + 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StClear  = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StLatch  = 3'd3;
  localparam logic [2:0] StSend   = 3'd4;
  localparam logic [2:0] StPace   = 3'd5;
  localparam logic [2:0] StStep   = 3'd6;
  localparam logic [2:0] StDone   = 3'd7;

  logic [2:0]      state_q, state_d;
  logic [7:0]      remaining_q, remaining_d;
  logic [7:0]      term_idx_q, term_idx_d;
  logic            ovf_err_q, ovf_err_d;
  logic [bits-1:0] ro_q, ro_d;
  logic [SW-1:0]   shreg_q, shreg_d;
  logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;

`ifdef FIB_SEQ_PACE_EN
  logic [31:0]     pace_cnt_q, pace_cnt_d;
`else
  logic            unused_pace;
  assign unused_pace = ^32'(pace_cycles);
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    term_idx_d  = term_idx_q;
    ovf_err_d   = ovf_err_q;
    ro_d        = ro_q;
    shreg_d     = shreg_q;
    byte_cnt_d  = byte_cnt_q;
`ifdef FIB_SEQ_PACE_EN
    pace_cnt_d  = pace_cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          remaining_d = cmd_data;
          term_idx_d  = 8'd0;
          ovf_err_d   = 1'b0;
          state_d     = (cmd_data == 8'd0) ? StDone : StClear;
        end
      end
      StClear:  state_d = StSettle;
      StStep:   state_d = StSettle;
      StSettle: state_d = StLatch;
      StLatch: begin
        ro_d                = dp_value;
        shreg_d             = '0;
        shreg_d[bits-1:0]   = dp_value;
        byte_cnt_d          = BCW'(NBYTES);
        if (term_idx_q != 8'hff) term_idx_d = term_idx_q + 8'd1;
        state_d             = StSend;
      end
      StSend: begin
        if (tx_ready) begin
          shreg_d    = shreg_q << 8;
          byte_cnt_d = byte_cnt_q - BCW'(1);
          if (byte_cnt_q == BCW'(1)) begin
            remaining_d = remaining_q - 8'd1;
            if (remaining_q == 8'd1) begin
              state_d = StDone;
            end else if (dp_ovf) begin
              ovf_err_d = 1'b1;
              state_d   = StDone;
            end else begin
`ifdef FIB_SEQ_PACE_EN
              pace_cnt_d = '0;
              state_d    = StPace;
`else
              state_d    = StStep;
`endif
            end
          end
        end
      end
      StPace: begin
`ifdef FIB_SEQ_PACE_EN
        if (pace_cnt_q == 32'(pace_cycles - 1)) begin
          state_d = StStep;
        end else begin
          pace_cnt_d = pace_cnt_q + 32'd1;
        end
`else
        state_d = StStep;
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort wins over the normal transition but keeps a byte handshaken in the same cycle.
    if (abort && (state_q != StIdle) && (state_q != StDone)) state_d = StDone;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= 8'd0;
      term_idx_q  <= 8'd0;
      ovf_err_q   <= 1'b0;
      ro_q        <= '0;
      shreg_q     <= '0;
      byte_cnt_q  <= '0;
`ifdef FIB_SEQ_PACE_EN
      pace_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      term_idx_q  <= term_idx_d;
      ovf_err_q   <= ovf_err_d;
      ro_q        <= ro_d;
      shreg_q     <= shreg_d;
      byte_cnt_q  <= byte_cnt_d;
`ifdef FIB_SEQ_PACE_EN
      pace_cnt_q  <= pace_cnt_d;
`endif
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign dp_clear  = (state_q == StClear);
  assign dp_step   = (state_q == StStep);
  assign tx_valid  = (state_q == StSend);
  assign done      = (state_q == StDone);
  assign tx_data   = shreg_q[SW-1 -: 8];
  assign Ro        = ro_q;
  assign term_idx  = term_idx_q;
  assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_fib_exec_sequencer.sv
// Scoreboard bench for fib_exec_sequencer: 8-bit and 16-bit instances driven by Fibonacci
// datapath models; expected bytes are queued at command time and popped on each handshake.
module tb_fib_exec_sequencer;
  localparam int unsigned PaceCycles = 5;
`ifdef FIB_SEQ_PACE_EN
  localparam int Pace = PaceCycles;
`else
  localparam int Pace = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid8 = 1'b0, cmd_valid16 = 1'b0;
  logic [7:0] cmd_data = 8'd0;
  logic abort = 1'b0, tx_ready = 1'b1;

  logic cmd_ready8, dp_clear8, dp_step8, tx_valid8, busy8, done8, ovf_err8, dp_ovf8;
  logic [7:0] tx_data8, term_idx8, dp_value8, Ro8;
  logic cmd_ready16, dp_clear16, dp_step16, tx_valid16, busy16, done16, ovf_err16, dp_ovf16;
  logic [7:0] tx_data16, term_idx16;
  logic [15:0] dp_value16, Ro16;

  always #5 clk = ~clk;

  fib_exec_sequencer #(.bits(8), .pace_cycles(PaceCycles)) u_dut8 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid8), .cmd_data(cmd_data), .cmd_ready(cmd_ready8),
    .abort(abort), .dp_clear(dp_clear8), .dp_step(dp_step8), .dp_value(dp_value8),
    .dp_ovf(dp_ovf8), .tx_valid(tx_valid8), .tx_data(tx_data8), .tx_ready(tx_ready),
    .Ro(Ro8), .term_idx(term_idx8), .busy(busy8), .done(done8), .ovf_err(ovf_err8)
  );

  fib_exec_sequencer #(.bits(16), .pace_cycles(PaceCycles)) u_dut16 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid16), .cmd_data(cmd_data), .cmd_ready(cmd_ready16),
    .abort(abort), .dp_clear(dp_clear16), .dp_step(dp_step16), .dp_value(dp_value16),
    .dp_ovf(dp_ovf16), .tx_valid(tx_valid16), .tx_data(tx_data16), .tx_ready(tx_ready),
    .Ro(Ro16), .term_idx(term_idx16), .busy(busy16), .done(done16), .ovf_err(ovf_err16)
  );

  // Datapath models: value is F(a); overflow flags that the next term exceeds the width.
  longint a8, b8, a16, b16;
  always @(posedge clk) begin
    if (rst) begin
      a8 <= 0; b8 <= 1; a16 <= 0; b16 <= 1;
    end else begin
      if (dp_clear8) begin a8 <= 0; b8 <= 1; end
      else if (dp_step8) begin a8 <= b8; b8 <= a8 + b8; end
      if (dp_clear16) begin a16 <= 0; b16 <= 1; end
      else if (dp_step16) begin a16 <= b16; b16 <= a16 + b16; end
    end
  end
  assign dp_value8  = a8[7:0];
  assign dp_ovf8    = (b8 > 255);
  assign dp_value16 = a16[15:0];
  assign dp_ovf16   = (b16 > 65535);

  bit sel16 = 1'b0;
  logic m_cmd_valid, m_cmd_ready, m_clear, m_step, m_done, m_busy, m_tx_valid;
  logic [7:0] m_tx_data;
  assign m_cmd_valid = sel16 ? cmd_valid16 : cmd_valid8;
  assign m_cmd_ready = sel16 ? cmd_ready16 : cmd_ready8;
  assign m_clear     = sel16 ? dp_clear16  : dp_clear8;
  assign m_step      = sel16 ? dp_step16   : dp_step8;
  assign m_done      = sel16 ? done16      : done8;
  assign m_busy      = sel16 ? busy16      : busy8;
  assign m_tx_valid  = sel16 ? tx_valid16  : tx_valid8;
  assign m_tx_data   = sel16 ? tx_data16   : tx_data8;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, clear_cnt = 0, step_cnt = 0, done_cnt = 0, hs_cnt = 0;
  int acc_cyc = 0, clr_cyc = 0, done_cyc = 0, last_hs_cyc = 0, abort_cyc = 0;
  int rise_q[$];
  logic [7:0] exp_q[$];
  int exp_idx = 0;
  bit exp_ovf = 0;
  longint exp_ro = 0;
  bit prev_valid = 0, hold_chk = 0;
  logic [7:0] hold_data = 8'd0;

  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    if (rst) begin
      prev_valid = 0;
      hold_chk   = 0;
    end else begin
      if (m_cmd_valid && m_cmd_ready) acc_cyc = cyc;
      if (m_clear) begin clear_cnt++; clr_cyc = cyc; end
      if (m_step) step_cnt++;
      if (m_done) begin done_cnt++; done_cyc = cyc; end
      if (abort && m_busy) abort_cyc = cyc;
      if (hold_chk) begin
        n_checks++;
        if (m_tx_valid !== 1'b1 || m_tx_data !== hold_data)
          $display("FAIL hold_stable: tx_valid=%b tx_data=%h, required 1/%h", m_tx_valid,
                   m_tx_data, hold_data);
        else n_pass++;
      end
      if (m_tx_valid && !prev_valid) rise_q.push_back(cyc);
      if (m_tx_valid && tx_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL tx_byte: got %h, required no byte", m_tx_data);
        end else begin
          e = exp_q.pop_front();
          if (m_tx_data !== e) $display("FAIL tx_byte: got %h, required %h", m_tx_data, e);
          else n_pass++;
        end
      end
      hold_chk   = m_tx_valid && !tx_ready && !abort;
      hold_data  = m_tx_data;
      prev_valid = m_tx_valid;
    end
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int n, input bit wide);
    longint a, b, t, mx;
    int nb;
    a = 0; b = 1;
    nb = wide ? 2 : 1;
    mx = wide ? 65535 : 255;
    exp_idx = 0;
    exp_ovf = 0;
    for (int k = 0; k < n; k++) begin
      for (int j = nb - 1; j >= 0; j--) exp_q.push_back(8'((a >> (8 * j)) & 255));
      exp_idx++;
      exp_ro = a;
      if (k + 1 == n) break;
      if (b > mx) begin exp_ovf = 1; break; end
      t = a + b; a = b; b = t;
    end
    drive_edge();
    cmd_data = 8'(n);
    if (wide) cmd_valid16 = 1'b1;
    else cmd_valid8 = 1'b1;
    drive_edge();
    cmd_valid8 = 1'b0;
    cmd_valid16 = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin sample(); n++; end
    n_checks++;
    if (done_cnt == start) $display("FAIL %s_timeout: no done in %0d cycles, required done", name, budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) drive_edge();
    rst = 1'b0;
    sample();
    n_checks++; if ({cmd_ready8, busy8, done8, tx_valid8, dp_clear8, dp_step8, ovf_err8} !== 7'b1000000)
      $display("FAIL reset_ctrl8: got %b, required 1000000",
               {cmd_ready8, busy8, done8, tx_valid8, dp_clear8, dp_step8, ovf_err8}); else n_pass++;
    n_checks++; if ({tx_data8, Ro8, term_idx8} !== 24'd0)
      $display("FAIL reset_data8: got %h, required 0", {tx_data8, Ro8, term_idx8}); else n_pass++;
    n_checks++; if ({cmd_ready16, busy16, done16, tx_valid16, ovf_err16} !== 5'b10000)
      $display("FAIL reset_ctrl16: got %b, required 10000",
               {cmd_ready16, busy16, done16, tx_valid16, ovf_err16}); else n_pass++;
    n_checks++; if ({tx_data16, Ro16, term_idx16} !== 32'd0)
      $display("FAIL reset_data16: got %h, required 0", {tx_data16, Ro16, term_idx16}); else n_pass++;
  endtask

  task automatic test_basic();
    int c0, s0, d0;
    sel16 = 0;
    c0 = clear_cnt; s0 = step_cnt; d0 = done_cnt;
    rise_q.delete();
    send_cmd(5, 0);
    wait_done(200, "basic");
    n_checks++; if (m_cmd_ready !== 1'b0)
      $display("FAIL basic_ready_in_done: got %b, required 0", m_cmd_ready); else n_pass++;
    n_checks++; if (done_cyc !== last_hs_cyc + 1)
      $display("FAIL basic_done_timing: got %0d, required %0d", done_cyc, last_hs_cyc + 1); else n_pass++;
    sample();
    n_checks++; if (m_cmd_ready !== 1'b1)
      $display("FAIL basic_ready_after_done: got %b, required 1", m_cmd_ready); else n_pass++;
    n_checks++; if (exp_q.size() != 0)
      $display("FAIL basic_bytes_left: got %0d, required 0", exp_q.size()); else n_pass++;
    n_checks++; if (clear_cnt - c0 != 1 || step_cnt - s0 != 4 || done_cnt - d0 != 1)
      $display("FAIL basic_pulses: clear/step/done got %0d/%0d/%0d, required 1/4/1",
               clear_cnt - c0, step_cnt - s0, done_cnt - d0); else n_pass++;
    n_checks++; if (Ro8 !== 8'(exp_ro) || term_idx8 !== 8'(exp_idx) || ovf_err8 !== 1'b0)
      $display("FAIL basic_result: Ro/idx/ovf got %0d/%0d/%b, required %0d/%0d/0", Ro8, term_idx8,
               ovf_err8, exp_ro, exp_idx); else n_pass++;
    n_checks++; if (clr_cyc != acc_cyc + 1)
      $display("FAIL basic_clear_latency: got %0d, required %0d", clr_cyc - acc_cyc, 1); else n_pass++;
    n_checks++; if (rise_q.size() != 5 || rise_q[0] != acc_cyc + 4)
      $display("FAIL basic_first_valid: terms %0d at +%0d, required 5 at +4", rise_q.size(),
               rise_q[0] - acc_cyc); else n_pass++;
    n_checks++; if (rise_q[1] - rise_q[0] != 4 + Pace || rise_q[4] - rise_q[3] != 4 + Pace)
      $display("FAIL basic_term_period: got %0d, required %0d", rise_q[1] - rise_q[0], 4 + Pace);
    else n_pass++;
  endtask

  task automatic test_overflow();
    sel16 = 0;
    send_cmd(15, 0);
    wait_done(600, "ovf");
    n_checks++; if (exp_q.size() != 0)
      $display("FAIL ovf_bytes_left: got %0d, required 0", exp_q.size()); else n_pass++;
    n_checks++; if (term_idx8 !== 8'(exp_idx) || Ro8 !== 8'(exp_ro))
      $display("FAIL ovf_result: idx/Ro got %0d/%0d, required %0d/%0d", term_idx8, Ro8, exp_idx,
               exp_ro); else n_pass++;
    n_checks++; if (ovf_err8 !== exp_ovf)
      $display("FAIL ovf_flag: got %b, required %b", ovf_err8, exp_ovf); else n_pass++;
  endtask

  task automatic test_zero();
    int c0, h0;
    sel16 = 0;
    c0 = clear_cnt; h0 = hs_cnt;
    rise_q.delete();
    send_cmd(0, 0);
    wait_done(20, "zero");
    n_checks++; if (done_cyc != acc_cyc + 1)
      $display("FAIL zero_done_latency: got %0d, required 1", done_cyc - acc_cyc); else n_pass++;
    n_checks++; if (clear_cnt != c0 || hs_cnt != h0 || rise_q.size() != 0)
      $display("FAIL zero_activity: clears %0d bytes %0d valids %0d, required 0", clear_cnt - c0,
               hs_cnt - h0, rise_q.size()); else n_pass++;
    n_checks++; if (ovf_err8 !== 1'b0 || term_idx8 !== 8'd0 || Ro8 !== 8'd233)
      $display("FAIL zero_state: ovf/idx/Ro got %b/%0d/%0d, required 0/0/233", ovf_err8, term_idx8,
               Ro8); else n_pass++;
  endtask

  task automatic test_wide();
    int c0, s0, d0;
    sel16 = 1;
    c0 = clear_cnt; s0 = step_cnt; d0 = done_cnt;
    send_cmd(3, 1);
    repeat (2) sample();
    drive_edge();
    cmd_data = 8'd7;
    cmd_valid16 = 1'b1;
    drive_edge();
    cmd_valid16 = 1'b0;
    wait_done(200, "wide");
    sample();
    n_checks++; if (exp_q.size() != 0)
      $display("FAIL wide_bytes_left: got %0d, required 0", exp_q.size()); else n_pass++;
    n_checks++; if (term_idx16 !== 8'd3 || Ro16 !== 16'(exp_ro))
      $display("FAIL wide_result: idx/Ro got %0d/%0d, required 3/%0d", term_idx16, Ro16, exp_ro);
    else n_pass++;
    n_checks++; if (clear_cnt - c0 != 1 || step_cnt - s0 != 2 || done_cnt - d0 != 1)
      $display("FAIL wide_pulses: clear/step/done got %0d/%0d/%0d, required 1/2/1",
               clear_cnt - c0, step_cnt - s0, done_cnt - d0); else n_pass++;
    sel16 = 0;
  endtask

  task automatic test_backpressure();
    int h0, n;
    sel16 = 0;
    h0 = hs_cnt;
    send_cmd(3, 0);
    n = 0;
    while (hs_cnt < h0 + 1 && n < 50) begin sample(); n++; end
    drive_edge();
    tx_ready = 1'b0;
    n = 0;
    while (!m_tx_valid && n < 50) begin sample(); n++; end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) sample();
      n_checks++; if (m_tx_valid !== 1'b1 || m_tx_data !== 8'h01)
        $display("FAIL bp_stall_%0d: valid/data got %b/%h, required 1/01", i, m_tx_valid, m_tx_data);
      else n_pass++;
    end
    drive_edge();
    tx_ready = 1'b1;
    wait_done(100, "bp");
    n_checks++; if (hs_cnt - h0 != 3 || exp_q.size() != 0)
      $display("FAIL bp_bytes: got %0d sent %0d left, required 3/0", hs_cnt - h0, exp_q.size());
    else n_pass++;
    n_checks++; if (term_idx8 !== 8'd3)
      $display("FAIL bp_term_idx: got %0d, required 3", term_idx8); else n_pass++;
  endtask

  task automatic test_abort();
    int h0, d0, n;
    sel16 = 0;
    h0 = hs_cnt; d0 = done_cnt;
    send_cmd(10, 0);
    n = 0;
    while (hs_cnt < h0 + 3 && n < 100) begin sample(); n++; end
    drive_edge();
    tx_ready = 1'b0;
    n = 0;
    while (!m_tx_valid && n < 50) begin sample(); n++; end
    drive_edge();
    abort = 1'b1;
    tx_ready = 1'b1;
    drive_edge();
    abort = 1'b0;
    sample();
    n_checks++; if (done_cnt - d0 != 1 || done_cyc != abort_cyc + 1)
      $display("FAIL abort_done: count %0d at +%0d, required 1 at +1", done_cnt - d0,
               done_cyc - abort_cyc); else n_pass++;
    sample();
    n_checks++; if (m_cmd_ready !== 1'b1)
      $display("FAIL abort_ready: got %b, required 1", m_cmd_ready); else n_pass++;
    n_checks++; if (hs_cnt - h0 != 4 || exp_q.size() != 6)
      $display("FAIL abort_bytes: sent %0d left %0d, required 4/6", hs_cnt - h0, exp_q.size());
    else n_pass++;
    n_checks++; if (term_idx8 !== 8'd4 || ovf_err8 !== 1'b0)
      $display("FAIL abort_state: idx/ovf got %0d/%b, required 4/0", term_idx8, ovf_err8); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid_run();
    int d0;
    sel16 = 0;
    send_cmd(10, 0);
    repeat (6) sample();
    drive_edge();
    rst = 1'b1;
    d0 = done_cnt;
    drive_edge();
    rst = 1'b0;
    sample();
    n_checks++; if (cmd_ready8 !== 1'b1 || busy8 !== 1'b0 || tx_valid8 !== 1'b0)
      $display("FAIL rst_mid_state: ready/busy/valid got %b/%b/%b, required 1/0/0", cmd_ready8,
               busy8, tx_valid8); else n_pass++;
    n_checks++; if (term_idx8 !== 8'd0 || Ro8 !== 8'd0)
      $display("FAIL rst_mid_regs: idx/Ro got %0d/%0d, required 0/0", term_idx8, Ro8); else n_pass++;
    repeat (3) sample();
    n_checks++; if (done_cnt != d0)
      $display("FAIL rst_mid_done: got %0d pulses, required 0", done_cnt - d0); else n_pass++;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero();
    test_wide();
    test_backpressure();
    test_abort();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule
